// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: decode constants and FSM states.
package muldiv_pkg;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational decode of an M-extension op: class, result half and operand signedness.
// sel_hi picks the high product half for multiplies and the remainder for divides.
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [6:0] i_func7,
  input  logic [2:0] i_func3,
  output logic       o_is_muldiv,
  output logic       o_is_div,
  output logic       o_sel_hi,
  output logic       o_a_signed,
  output logic       o_b_signed
);

  assign o_is_muldiv = (i_alu_op == ALU_OP_RTYPE) && (i_func7 == FUNC7_MULDIV);

  always_comb begin
    o_is_div   = 1'b0;
    o_sel_hi   = 1'b0;
    o_a_signed = 1'b0;
    o_b_signed = 1'b0;
    case (i_func3)
      F3_MUL:    begin o_a_signed = 1'b1; o_b_signed = 1'b1; end
      F3_MULH:   begin o_sel_hi = 1'b1; o_a_signed = 1'b1; o_b_signed = 1'b1; end
      F3_MULHSU: begin o_sel_hi = 1'b1; o_a_signed = 1'b1; end
      F3_MULHU:  begin o_sel_hi = 1'b1; end
      F3_DIV:    begin o_is_div = 1'b1; o_a_signed = 1'b1; o_b_signed = 1'b1; end
      F3_DIVU:   begin o_is_div = 1'b1; end
      F3_REM:    begin o_is_div = 1'b1; o_sel_hi = 1'b1; o_a_signed = 1'b1; o_b_signed = 1'b1; end
      F3_REMU:   begin o_is_div = 1'b1; o_sel_hi = 1'b1; end
      default:   begin o_is_div = 1'b0; end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: WIDTH+2 cycles to out_valid, 1 cycle for div-by-zero/overflow.
// One op in flight; result held in DONE until out_ready, in_ready only in IDLE, flush wins.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [6:0]       func7,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             is_muldiv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_opb, r_result;
  logic               r_is_div, r_sel_hi, r_neg_res, r_neg_rem;

  logic               w_is_div, w_sel_hi, w_a_signed, w_b_signed;
  logic               w_a_neg, w_b_neg, w_div_zero, w_div_ovf, w_special, w_accept, w_fits;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_special_res, w_quo, w_rem, w_fix_res;
  logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_rem_sub;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  muldiv_decode u_decode (
    .i_alu_op    (alu_op),
    .i_func7     (func7),
    .i_func3     (func3),
    .o_is_muldiv (is_muldiv),
    .o_is_div    (w_is_div),
    .o_sel_hi    (w_sel_hi),
    .o_a_signed  (w_a_signed),
    .o_b_signed  (w_b_signed)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;

  assign w_a_neg    = w_a_signed & op_a[WIDTH-1];
  assign w_b_neg    = w_b_signed & op_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -op_a : op_a;
  assign w_b_mag    = w_b_neg ? -op_b : op_b;
  assign w_div_zero = w_is_div & (op_b == '0);
  assign w_div_ovf  = w_is_div & w_a_signed & (op_a == MOST_NEG) & (op_b == '1);
  assign w_special  = w_div_zero | w_div_ovf;
  assign w_accept   = in_valid & in_ready & is_muldiv & ~flush;

  // Divide-by-zero and signed overflow skip the iteration entirely.
  assign w_special_res = w_sel_hi ? (w_div_zero ? op_a : '0)
                                  : (w_div_zero ? '1   : op_a);

  // Multiply: {r_hi,r_lo} shifts right with the partial sum entering at the top.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_opb};
  assign w_fits    = ~w_rem_sub[WIDTH];

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quo      = r_neg_res ? -r_lo : r_lo;
  assign w_rem      = r_neg_rem ? -r_hi : r_hi;
  assign w_fix_res  = r_is_div ? (r_sel_hi ? w_rem : w_quo)
                               : (r_sel_hi ? w_prod_fix[2*WIDTH-1:WIDTH] : w_prod_fix[WIDTH-1:0]);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opb     <= '0;
      r_result  <= '0;
      r_is_div  <= 1'b0;
      r_sel_hi  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_div  <= w_is_div;
            r_sel_hi  <= w_sel_hi;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= w_is_div ? w_a_mag : w_b_mag;
            r_opb     <= w_is_div ? w_b_mag : w_a_mag;
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= ST_DONE;
            end else begin
              r_state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_hi <= w_fits ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_fits};
          end else begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
          if (r_cnt == LAST_ITER) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_fix_res;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
